// File: rtl/alu_sweep_checker.sv
// Sweeps all 2048 {cin,a,b,s} vectors into the 4-bit add/sub system, holds each
// for a settle window, then checks {cout,d} against a golden model.
module alu_sweep_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       op_a,
  output logic [3:0]       op_b,
  output logic [1:0]       op_s,
  output logic             op_cin,
  input  logic [3:0]       dut_d,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [10:0]      first_fail_vec,
  output logic [4:0]       first_fail_exp,
  output logic [4:0]       first_fail_got
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam int            SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [10:0]   LAST = 11'h7FF;

  state_t           r_state, w_state_nxt;
  logic [10:0]      r_vec;
  logic [SW-1:0]    r_cnt;
  logic             w_load;
  logic [3:0]       w_y;
  logic [4:0]       w_exp;
  logic [4:0]       w_got;

  assign {op_cin, op_a, op_b, op_s} = r_vec;

  // Golden model of the mux-selected B operand feeding the adder
  always_comb begin
    w_y = op_b;
    case (op_s)
      2'b00: w_y = op_b;
      2'b01: w_y = ~op_b;
      2'b10: w_y = 4'b0000;
      2'b11: w_y = 4'b1111;
      default: w_y = op_b;
    endcase
  end

  assign w_exp = {1'b0, op_a} + {1'b0, w_y} + {4'b0000, op_cin};
  assign w_got = {dut_cout, dut_d};

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE, DONE: if (start) begin
        w_state_nxt = SETTLE;
        w_load      = 1'b1;
      end
      SETTLE: if (r_cnt == '0) w_state_nxt = CHECK;
      CHECK:  w_state_nxt = (r_vec == LAST) ? DONE : SETTLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec            <= '0;
      r_cnt            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_exp   <= '0;
      first_fail_got   <= '0;
    end else if (w_load) begin
      r_vec            <= '0;
      r_cnt            <= LOAD;
      busy             <= 1'b1;
      done             <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_exp   <= '0;
      first_fail_got   <= '0;
    end else begin
      case (r_state)
        SETTLE: if (r_cnt != '0) r_cnt <= r_cnt - SW'(1);
        CHECK: begin
          if (w_got == w_exp) begin
            pass_cnt <= pass_cnt + CNT_W'(1);
          end else begin
            fail_cnt <= fail_cnt + CNT_W'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= r_vec;
              first_fail_exp   <= w_exp;
              first_fail_got   <= w_got;
            end
          end
          // Last vector stays on op_* after the sweep completes
          if (r_vec == LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            r_vec <= r_vec + 11'd1;
            r_cnt <= LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Directed bench: a behavioural add/sub system with selectable faults sits
// behind the checker; each task checks one scenario against hand values.
module tb_alu_sweep_checker;

  logic        clk, rst_n, start;
  logic [3:0]  op_a, op_b, dut_d;
  logic [1:0]  op_s;
  logic        op_cin, dut_cout, busy, done, first_fail_valid;
  logic [11:0] pass_cnt, fail_cnt;
  logic [10:0] first_fail_vec;
  logic [4:0]  first_fail_exp, first_fail_got;

  int total = 0;
  int bad   = 0;
  int fault = 0;  // 0 ideal, 1 d[2] stuck at 0, 2 cout inverted at vec 3C4

  alu_sweep_checker #(.SETTLE_CYCLES(4), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_cin(op_cin),
    .dut_d(dut_d), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec),
    .first_fail_exp(first_fail_exp), .first_fail_got(first_fail_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-delay behavioural add/sub system with optional planted faults
  logic [3:0] sy;
  logic [4:0] ssum;
  always_comb begin
    sy = op_b;
    case (op_s)
      2'b00: sy = op_b;
      2'b01: sy = ~op_b;
      2'b10: sy = 4'h0;
      default: sy = 4'hF;
    endcase
    ssum = {1'b0, op_a} + {1'b0, sy} + {4'h0, op_cin};
    if (fault == 1) ssum[2] = 1'b0;
    if (fault == 2 && {op_cin, op_a, op_b, op_s} == 11'h3C4) ssum[4] = ~ssum[4];
    dut_d    = ssum[3:0];
    dut_cout = ssum[4];
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulse start, then count cycles with busy high until done (bounded).
  // A nonnegative poke_at re-pulses start that many cycles into the sweep.
  task automatic run_sweep(input int poke_at, output int hi);
    int n;
    start = 1'b1; tick(); start = 1'b0;
    hi = 0; n = 0;
    while (!done && n < 12000) begin
      if (busy) hi++;
      if (n == poke_at) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    #3;
    total++;
    if ({op_a, op_b, op_s, op_cin, busy, done, pass_cnt, fail_cnt, first_fail_valid,
         first_fail_vec, first_fail_exp, first_fail_got} !== '0)
      begin bad++; $display("FAIL reset_outputs got busy=%b done=%b pass=%0d fail=%0d op=%h want all 0",
        busy, done, pass_cnt, fail_cnt, {op_cin, op_a, op_b, op_s}); end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0)
        begin bad++; $display("FAIL idle_no_start cycle %0d got busy=%b done=%b want 0 0", i, busy, done); end
    end
  endtask

  task automatic test_ideal_sweep();
    int hi;
    fault = 0;
    run_sweep(-1, hi);
    total++;
    if (hi !== 10240) begin bad++; $display("FAIL ideal_busy_cycles got %0d want 10240", hi); end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ideal_done got done=%b busy=%b want 1 0", done, busy); end
    total++;
    if (pass_cnt !== 12'd2048 || fail_cnt !== 12'd0 || first_fail_valid !== 1'b0)
      begin bad++; $display("FAIL ideal_counts got pass=%0d fail=%0d ffv=%b want 2048 0 0", pass_cnt, fail_cnt, first_fail_valid); end
    total++;
    if ({op_cin, op_a, op_b, op_s} !== 11'h7FF)
      begin bad++; $display("FAIL ideal_last_vec_held got %h want 7ff", {op_cin, op_a, op_b, op_s}); end
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (done !== 1'b1 || pass_cnt !== 12'd2048)
      begin bad++; $display("FAIL done_hold got done=%b pass=%0d want 1 2048", done, pass_cnt); end
  endtask

  task automatic test_stuck_d2();
    int hi;
    fault = 1;
    run_sweep(-1, hi);
    total++;
    if (fail_cnt !== 12'd1024 || pass_cnt !== 12'd1024)
      begin bad++; $display("FAIL stuck_counts got pass=%0d fail=%0d want 1024 1024", pass_cnt, fail_cnt); end
    total++;
    if (first_fail_valid !== 1'b1 || first_fail_vec !== 11'd1)
      begin bad++; $display("FAIL stuck_first_vec got ffv=%b vec=%h want 1 001", first_fail_valid, first_fail_vec); end
    total++;
    if (first_fail_exp !== 5'b01111 || first_fail_got !== 5'b01011)
      begin bad++; $display("FAIL stuck_first_data got exp=%b got=%b want 01111 01011", first_fail_exp, first_fail_got); end
  endtask

  task automatic test_restart_from_done();
    int n;
    fault = 0;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || pass_cnt !== '0 || fail_cnt !== '0 || first_fail_valid !== 1'b0)
      begin bad++; $display("FAIL restart_clear got done=%b busy=%b pass=%0d fail=%0d ffv=%b want 0 1 0 0 0",
        done, busy, pass_cnt, fail_cnt, first_fail_valid); end
    total++;
    if ({op_cin, op_a, op_b, op_s} !== 11'h000)
      begin bad++; $display("FAIL restart_vec0 got %h want 000", {op_cin, op_a, op_b, op_s}); end
    for (int i = 0; i < 4; i++) tick();
    total++;
    if ({op_cin, op_a, op_b, op_s} !== 11'h000 || pass_cnt !== '0)
      begin bad++; $display("FAIL vec0_hold got vec=%h pass=%0d want 000 0", {op_cin, op_a, op_b, op_s}, pass_cnt); end
    tick();
    total++;
    if ({op_cin, op_a, op_b, op_s} !== 11'h001 || pass_cnt !== 12'd1)
      begin bad++; $display("FAIL vec1_step got vec=%h pass=%0d want 001 1", {op_cin, op_a, op_b, op_s}, pass_cnt); end
    n = 0;
    while (!done && n < 12000) begin tick(); n++; end
    total++;
    if (done !== 1'b1 || pass_cnt !== 12'd2048)
      begin bad++; $display("FAIL restart_full got done=%b pass=%0d want 1 2048", done, pass_cnt); end
  endtask

  task automatic test_cout_flip();
    int hi;
    fault = 2;
    run_sweep(-1, hi);
    total++;
    if (fail_cnt !== 12'd1 || pass_cnt !== 12'd2047 || first_fail_vec !== 11'h3C4)
      begin bad++; $display("FAIL flip_counts got fail=%0d pass=%0d vec=%h want 1 2047 3c4", fail_cnt, pass_cnt, first_fail_vec); end
    total++;
    if (first_fail_exp !== 5'b10000 || first_fail_got !== 5'b00000)
      begin bad++; $display("FAIL flip_data got exp=%b got=%b want 10000 00000", first_fail_exp, first_fail_got); end
  endtask

  task automatic test_start_while_busy();
    int hi;
    fault = 0;
    run_sweep(100, hi);
    total++;
    if (hi !== 10240) begin bad++; $display("FAIL busy_start_timing got %0d want 10240", hi); end
    total++;
    if (pass_cnt !== 12'd2048 || fail_cnt !== 12'd0)
      begin bad++; $display("FAIL busy_start_counts got pass=%0d fail=%0d want 2048 0", pass_cnt, fail_cnt); end
  endtask

  task automatic test_reset_mid_sweep();
    int hi;
    fault = 1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    total++;
    if (fail_cnt === 12'd0 || busy !== 1'b1)
      begin bad++; $display("FAIL midsweep_pre got fail=%0d busy=%b want nonzero 1", fail_cnt, busy); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({op_a, op_b, op_s, op_cin, busy, done, pass_cnt, fail_cnt, first_fail_valid,
         first_fail_vec, first_fail_exp, first_fail_got} !== '0)
      begin bad++; $display("FAIL midsweep_reset got busy=%b pass=%0d fail=%0d ffv=%b op=%h want all 0",
        busy, pass_cnt, fail_cnt, first_fail_valid, {op_cin, op_a, op_b, op_s}); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    fault = 0;
    run_sweep(-1, hi);
    total++;
    if (pass_cnt !== 12'd2048 || fail_cnt !== 12'd0 || hi !== 10240)
      begin bad++; $display("FAIL midsweep_restart got pass=%0d fail=%0d busy_cycles=%0d want 2048 0 10240",
        pass_cnt, fail_cnt, hi); end
  endtask

  initial begin
    test_reset();
    test_ideal_sweep();
    test_stuck_d2();
    test_restart_from_done();
    test_cout_flip();
    test_start_while_busy();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sweep_checker.md
Name: alu_sweep_checker

Overview:
- Clocked stimulus-and-check stage wrapped around the 4-bit add/subtract system (mux-selected B operand feeding a ripple or carry-lookahead adder).
- Upstream role: drives a, b, s and cin to the system for all 2048 input combinations, holding each stable for a programmable settle window.
- Downstream role: samples {cout,d} and compares it against an internal golden model.
- Replaces the free-running generator/analyzer pair with counted, self-checking results.

Parameters:
- SETTLE_CYCLES, 4: clock cycles each vector is held before the check cycle; legal range is 1 or more, and 0 is illegal.
- CNT_W, 12: width of the pass and fail counters; must be at least 12 so that 2048 fits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a sweep; sampled only in IDLE or DONE.
- op_a  out  4  operand A to the system.
- op_b  out  4  operand B to the system (before the mux).
- op_s  out  2  B-mux select to the system.
- op_cin  out  1  carry-in to the system.
- dut_d  in  4  sum result from the system.
- dut_cout  in  1  carry-out from the system.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high after a sweep completes; held until the next start or reset.
- pass_cnt  out  CNT_W  number of vectors that matched.
- fail_cnt  out  CNT_W  number of vectors that mismatched.
- first_fail_valid  out  1  set when the first mismatch of a sweep is recorded.
- first_fail_vec  out  11  {cin,a,b,s} of the first mismatch.
- first_fail_exp  out  5  expected {cout,d} at the first mismatch.
- first_fail_got  out  5  observed {dut_cout,dut_d} at the first mismatch.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low.
  - While rst_n is low, every output and all internal state is 0 and the FSM is in IDLE.
  - Reset takes effect immediately, including mid-sweep; nothing is retained.
- Vector encoding: an 11-bit index vec maps to {op_cin,op_a,op_b,op_s}, with cin as the MSB and s as the LSBs. The sweep runs vec = 0 to 2047 in increasing order.
- Golden model: the effective operand y is selected by op_s.
  - 00: y = op_b.
  - 01: y = ~op_b.
  - 10: y = 4'b0000.
  - 11: y = 4'b1111.
  - Expected value exp[4:0] = a + y + cin, computed as a 5-bit zero-extended sum; exp[4] is the carry-out.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1: load vec=0 onto op_*, clear pass_cnt, fail_cnt and first_fail_*, set busy=1, load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle; go to CHECK when the counter is 0.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle): at the exiting edge, compare {dut_cout,dut_d} with exp for the current vec.
  - Match: pass_cnt increments.
  - Mismatch: fail_cnt increments. If first_fail_valid is 0, capture vec, exp and got, and set first_fail_valid.
  - If vec < 2047: vec increments, op_* update at the same edge, the counter reloads, and the FSM goes to SETTLE.
  - If vec = 2047: busy=0, done=1, the FSM goes to DONE, and op_* hold the last vector.
- DONE:
  - Results hold.
  - start=1 behaves exactly as start in IDLE: it restarts the sweep and clears done and all results.
- Timing:
  - Each vector is stable at op_* for SETTLE_CYCLES+1 cycles before it is sampled.
  - A full sweep takes 2048×(SETTLE_CYCLES+1) cycles from the start edge to done rising.
- start while busy is ignored.
- Counters never wrap because pass_cnt + fail_cnt = 2048 at done.
- Invariant: pass_cnt + fail_cnt equals the number of CHECK cycles completed in the current sweep.
- dut_* inputs are sampled only in CHECK and are ignored in all other states.

Test Plan:
- Reset check: with rst_n low, all outputs are 0. Release rst_n without start: busy=0 and done=0 for 100 cycles.
- Ideal zero-delay behavioural DUT, SETTLE_CYCLES=4, pulse start:
  - busy is high for exactly 10240 cycles, then done=1.
  - pass_cnt=2048, fail_cnt=0, first_fail_valid=0.
- DUT with d[2] stuck at 0:
  - fail_cnt=1024, pass_cnt=1024.
  - first_fail_vec=11'd1, first_fail_exp=5'b01111, first_fail_got=5'b01011.
- Ideal DUT that inverts cout only at vec 11'h3C4 (cin=0, a=F, b=1, s=00):
  - fail_cnt=1, first_fail_vec=11'h3C4.
  - first_fail_exp=5'b10000, first_fail_got=5'b00000.
- Reset mid-sweep, then restart:
  - Pull rst_n low 500 cycles after start: outputs are 0 immediately.
  - Release and restart: the full sweep gives pass_cnt=2048.
- Start handling:
  - A start pulse at cycle 100 of a running sweep has no effect: results and timing are unchanged.
  - A start in DONE clears done and the counters on the next edge and begins the sweep again at vec 0.
